jtdd_snd_mixn: RTL and testbench



---
 rtl/jtdd_snd_mixn.sv | 196 +++++++++++++++++++
 tb/tb_jtdd_snd_mixn.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_snd_mixn.sv
// jtdd_snd_mixn: time-multiplexed N-channel audio mixer.
// One shared multiplier walks the channels one per clock. The gain-weighted
// sum is scaled to the output width, saturated, and held until the next frame.
// Gains are double-buffered: CPU writes land in the shadow bank, and the frame
// only sees the active bank, which is refreshed when a frame starts.
//
// Frame timing (cycle 0 = clk in which cen is sampled high in IDLE):
//   cycles 1..CH  : ACC, one product per clock
//   cycle  CH+1   : SCALE, mixed/sample already valid (registered at the last ACC edge)
//   cycle  CH+2   : back in IDLE, a new cen is accepted
// Handshake: cen is a fire-and-forget strobe. It is only accepted while busy=0;
// a strobe seen while busy=1 is dropped and does not disturb the running frame.
module jtdd_snd_mixn #(
  parameter int          CH   = 4,
  parameter int          W    = 16,
  parameter int          WOUT = 16,
  parameter logic [7:0]  GDEF = 8'h10,
  localparam int         AB   = $clog2(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic [CH*W-1:0]      ch,
  input  logic                 gain_we,
  input  logic [AB-1:0]        gain_addr,
  input  logic [7:0]           gain_din,
  input  logic                 clip_clr,
  output logic [WOUT-1:0]      mixed,
  output logic                 sample,
  output logic                 busy,
  output logic                 clip,
  output logic [1:0]           state_dbg
);

  // Accumulator sized so CH full-scale products at maximum gain cannot overflow
  localparam int AW = W + 9 + AB;
  // 4 fractional gain bits plus the input/output width reduction
  localparam int SH = 4 + W - WOUT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_SCALE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [AB-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [CH*W-1:0]         snap_q, snap_d;
  logic [CH-1:0][7:0]      shadow_q, shadow_d;
  logic [CH-1:0][7:0]      active_q, active_d;
  logic [WOUT-1:0]         mixed_q, mixed_d;
  logic                    sample_q, sample_d;
  logic                    busy_q, busy_d;
  logic                    clip_q, clip_d;
  logic                    sat_q, sat_d;

  // Datapath intermediates
  logic signed [W-1:0]     cur_s;
  logic [7:0]              cur_g;
  logic signed [8:0]       cur_g9;
  logic signed [W+8:0]     prod;
  logic signed [AW-1:0]    acc_sum;
  logic signed [AW-1:0]    shifted;
  logic [AW-WOUT:0]        hi_bits;
  logic                    sat_pos, sat_neg;
  logic [WOUT-1:0]         sat_out;

  assign mixed     = mixed_q;
  assign sample    = sample_q;
  assign busy      = busy_q;
  assign clip      = clip_q;
  assign state_dbg = state_q;

  // Channel select, multiply-accumulate and scale/saturate of the running sum
  always_comb begin
    cur_s = snap_q[W-1:0];
    cur_g = active_q[0];
    for (int i = 0; i < CH; i++) begin
      if (idx_q == AB'(i)) begin
        cur_s = snap_q[i*W +: W];
        cur_g = active_q[i];
      end
    end
    cur_g9  = {1'b0, cur_g};
    prod    = cur_s * cur_g9;
    acc_sum = acc_q + AW'(prod);
    shifted = acc_sum >>> SH;
    hi_bits = shifted[AW-1:WOUT-1];
    sat_pos = !shifted[AW-1] && (|hi_bits);
    sat_neg =  shifted[AW-1] && !(&hi_bits);
    if (sat_pos) begin
      sat_out = {1'b0, {(WOUT-1){1'b1}}};
    end else if (sat_neg) begin
      sat_out = {1'b1, {(WOUT-1){1'b0}}};
    end else begin
      sat_out = shifted[WOUT-1:0];
    end
  end

  // Next-state logic: gain file writes, frame sequencing and clip flag
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    snap_d   = snap_q;
    shadow_d = shadow_q;
    active_d = active_q;
    mixed_d  = mixed_q;
    sample_d = 1'b0;
    busy_d   = busy_q;
    clip_d   = clip_q;
    sat_d    = sat_q;

    // Out-of-range addresses match no channel and are dropped
    for (int i = 0; i < CH; i++) begin
      if (gain_we && (gain_addr == AB'(i))) begin
        shadow_d[i] = gain_din;
      end
    end

    if (clip_clr) begin
      clip_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cen) begin
          snap_d   = ch;
          active_d = shadow_d;
          acc_d    = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == AB'(CH-1)) begin
          // Last product: the output is registered now so it is visible in SCALE
          idx_d    = '0;
          mixed_d  = sat_out;
          sample_d = 1'b1;
          sat_d    = sat_pos | sat_neg;
          if (sat_pos | sat_neg) begin
            clip_d = 1'b1;
          end
          state_d  = S_SCALE;
        end
      end
      S_SCALE: begin
        // Re-assert clip so a clear arriving in the SCALE clock still loses
        if (sat_q) begin
          clip_d = 1'b1;
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      snap_q   <= '0;
      shadow_q <= {CH{GDEF}};
      active_q <= {CH{GDEF}};
      mixed_q  <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      clip_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      mixed_q  <= mixed_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      clip_q   <= clip_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_jtdd_snd_mixn.sv
// Directed testbench for jtdd_snd_mixn.
// dut_a: CH=4, W=WOUT=16 (timing, double buffering, saturation, clip, reset).
// dut_b: CH=5, W=16, WOUT=12 (fractional gain, width reduction, ignored address).
module tb_jtdd_snd_mixn;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut_a signals ----------------
  logic        cen_a;
  logic [63:0] ch_a;
  logic        gain_we_a;
  logic [1:0]  gain_addr_a;
  logic [7:0]  gain_din_a;
  logic        clip_clr_a;
  logic [15:0] mixed_a;
  logic        sample_a;
  logic        busy_a;
  logic        clip_a;
  logic [1:0]  state_a;

  // ---------------- dut_b signals ----------------
  logic        cen_b;
  logic [79:0] ch_b;
  logic        gain_we_b;
  logic [2:0]  gain_addr_b;
  logic [7:0]  gain_din_b;
  logic        clip_clr_b;
  logic [11:0] mixed_b;
  logic        sample_b;
  logic        busy_b;
  logic        clip_b;
  logic [1:0]  state_b;

  int total;
  int bad;

  jtdd_snd_mixn #(.CH(4), .W(16), .WOUT(16), .GDEF(8'h10)) dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen_a), .ch(ch_a),
    .gain_we(gain_we_a), .gain_addr(gain_addr_a), .gain_din(gain_din_a),
    .clip_clr(clip_clr_a), .mixed(mixed_a), .sample(sample_a),
    .busy(busy_a), .clip(clip_a), .state_dbg(state_a)
  );

  jtdd_snd_mixn #(.CH(5), .W(16), .WOUT(12), .GDEF(8'h10)) dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen_b), .ch(ch_b),
    .gain_we(gain_we_b), .gain_addr(gain_addr_b), .gain_din(gain_din_b),
    .clip_clr(clip_clr_b), .mixed(mixed_b), .sample(sample_b),
    .busy(busy_b), .clip(clip_b), .state_dbg(state_b)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [1:0] addr, input logic [7:0] din);
    gain_we_a   = 1'b1;
    gain_addr_a = addr;
    gain_din_a  = din;
    tick();
    gain_we_a   = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] addr, input logic [7:0] din);
    gain_we_b   = 1'b1;
    gain_addr_b = addr;
    gain_din_b  = din;
    tick();
    gain_we_b   = 1'b0;
  endtask

  // One full dut_a frame with per-cycle busy/sample checks.
  // do_w issues a gain write in cycle 2; clr_mask[k] drives clip_clr in cycle k.
  task automatic frame_a(input string tag, input int c0, input int c1, input int c2, input int c3,
                         input int expv, input logic exp_clip,
                         input logic do_w, input logic [1:0] waddr, input logic [7:0] wdin,
                         input logic [5:0] clr_mask);
    ch_a       = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    cen_a      = 1'b1;
    clip_clr_a = clr_mask[0];
    chk({tag, ":busy_c0"}, busy_a, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      cen_a       = 1'b0;
      clip_clr_a  = (k <= 5) ? clr_mask[k] : 1'b0;
      gain_we_a   = do_w && (k == 2);
      gain_addr_a = waddr;
      gain_din_a  = wdin;
      chk($sformatf("%s:busy_c%0d", tag, k), busy_a, (k <= 5) ? 1 : 0);
      chk($sformatf("%s:sample_c%0d", tag, k), sample_a, (k == 5) ? 1 : 0);
      if (k == 5) chk({tag, ":mixed"}, $signed(mixed_a), expv);
    end
    clip_clr_a = 1'b0;
    gain_we_a  = 1'b0;
    chk({tag, ":clip"}, clip_a, exp_clip);
  endtask

  // One dut_b frame (CH=5): sample expected in cycle 6 only.
  task automatic frame_b(input string tag, input int c0, input int c1, input int expv, input logic exp_clip);
    ch_b  = {48'd0, 16'(c1), 16'(c0)};
    cen_b = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      cen_b = 1'b0;
      if (k >= 5) chk($sformatf("%s:sample_c%0d", tag, k), sample_b, (k == 6) ? 1 : 0);
      if (k == 6) chk({tag, ":mixed"}, $signed(mixed_b), expv);
    end
    chk({tag, ":clip"}, clip_b, exp_clip);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cen_a = 1'b0; ch_a = '0; gain_we_a = 1'b0; gain_addr_a = '0; gain_din_a = '0; clip_clr_a = 1'b0;
    cen_b = 1'b0; ch_b = '0; gain_we_b = 1'b0; gain_addr_b = '0; gain_din_b = '0; clip_clr_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst:mixed",  $signed(mixed_a), 0);
    chk("rst:sample", sample_a, 0);
    chk("rst:busy",   busy_a, 0);
    chk("rst:clip",   clip_a, 0);
    chk("rst:state",  state_a, 0);

    // Single channel at unity gain: 1000*16 >>> 4
    frame_a("single", 1000, 0, 0, 0, 1000, 1'b0, 1'b0, 2'd0, 8'h00, 6'b0);

    // Gain written mid-frame only affects the following frame
    frame_a("dbuf_cur",  0, 0, -3000, 0, -3000, 1'b0, 1'b1, 2'd2, 8'h20, 6'b0);
    frame_a("dbuf_next", 0, 0, -3000, 0, -6000, 1'b0, 1'b0, 2'd0, 8'h00, 6'b0);

    // cen overrun: cycle 3 strobe dropped, cycle 6 strobe accepted
    ch_a  = {16'd0, 16'd0, 16'd0, 16'(1000)};
    cen_a = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      cen_a = (k == 3) || (k == 6);
      if (k == 2) ch_a = {16'd0, 16'd0, 16'd0, 16'(2000)};
      chk($sformatf("ovr:sample_c%0d", k), sample_a, (k == 5 || k == 11) ? 1 : 0);
      if (k == 5)  chk("ovr:mixed_first", $signed(mixed_a), 1000);
      if (k == 6)  chk("ovr:busy_c6", busy_a, 0);
      if (k == 11) chk("ovr:mixed_second", $signed(mixed_a), 2000);
    end
    cen_a = 1'b0;
    tick();

    // Saturation and sticky clip
    wr_a(2'd2, 8'h10);
    frame_a("sat_pos", 30000, 30000, 30000, 30000, 32767, 1'b1, 1'b0, 2'd0, 8'h00, 6'b0);
    frame_a("sat_neg", -30000, -30000, -30000, -30000, -32768, 1'b1, 1'b0, 2'd0, 8'h00, 6'b0);
    frame_a("clr_nosat", 500, 0, 0, 0, 500, 1'b0, 1'b0, 2'd0, 8'h00, 6'b000010);
    frame_a("clr_vs_sat", 30000, 30000, 30000, 30000, 32767, 1'b1, 1'b0, 2'd0, 8'h00, 6'b110000);

    // Fractional gains and WOUT=12 on dut_b
    wr_b(3'd0, 8'h08);
    wr_b(3'd1, 8'h28);
    frame_b("frac", 1600, -160, 25, 1'b0);
    wr_b(3'd5, 8'h00);
    frame_b("addr5_ignored", 1600, -160, 25, 1'b0);
    frame_b("frac_neg", -100, 0, -4, 1'b0);
    frame_b("b_sat", 32767, 32767, 2047, 1'b1);

    // Reset in the middle of a frame after a gain write
    wr_a(2'd0, 8'h30);
    ch_a  = {16'd0, 16'd0, 16'd0, 16'(1000)};
    cen_a = 1'b1;
    tick();
    cen_a = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst:mixed",  $signed(mixed_a), 0);
    chk("midrst:sample", sample_a, 0);
    chk("midrst:busy",   busy_a, 0);
    chk("midrst:clip",   clip_a, 0);
    chk("midrst:state",  state_a, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst:sample_hold%0d", k), sample_a, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("midrst:sample_after", sample_a, 0);
    // Unity gains restored: 1000 + (-3000)
    frame_a("post_rst", 1000, 0, -3000, 0, -2000, 1'b0, 1'b0, 2'd0, 8'h00, 6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
